// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous memory port.
// Each granted request runs IDLE -> ACCESS -> (WAIT) -> DONE and completes with a one-cycle ack.
module mem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  output logic          m_re,
  input  logic [DW-1:0] m_rdata,
  output logic [1:0]    owner,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;
  localparam logic [1:0] LAT      = 2'(RD_LAT);

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          last_b_q, last_b_d;  // 1 when B received the most recent grant
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          grant_b;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      cnt_q     <= 2'd0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant_b   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          // On a tie the port that did not win last time is served.
          grant_b  = b_req && (!a_req || !last_b_q);
          owner_d  = grant_b ? OWN_B : OWN_A;
          last_b_d = grant_b;
          we_d     = grant_b ? b_we    : a_we;
          addr_d   = grant_b ? b_addr  : a_addr;
          wdata_d  = grant_b ? b_wdata : a_wdata;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          if (owner_q == OWN_A) a_rdata_d = m_rdata;
          if (owner_q == OWN_B) b_rdata_d = m_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Address/data registers double as the memory bus, so they hold outside ACCESS.
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign m_we        = (state_q == S_ACCESS) &&  we_q;
  assign m_re        = (state_q == S_ACCESS) && !we_q;
  assign a_ack       = (state_q == S_DONE) && (owner_q == OWN_A);
  assign b_ack       = (state_q == S_DONE) && (owner_q == OWN_B);
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign owner       = owner_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic
// scored against a transaction-level memory model.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RD_LAT = 2;
  localparam int TW = 1 + AW + DW;
  localparam int AGE_LIMIT = 2 * (3 + RD_LAT) + 1;

  logic          clock, reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_we, m_re;
  logic [1:0]    owner, dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic [DW-1:0] ref_mem [16];
  logic [TW-1:0] a_exp_q[$];
  logic [TW-1:0] b_exp_q[$];

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
    .m_rdata(m_rdata), .owner(owner), .dbg_state_o(dbg_state)
  );

  // Clock/reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Memory behind the arbiter: read data valid RD_LAT cycles after the m_re cycle.
  always @(posedge clock) begin
    if (m_we) mem[m_addr] <= m_wdata;
    rd_pipe[0] <= mem[m_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_rdata = rd_pipe[RD_LAT-1];

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_xfer(input bit port_b, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, output logic [DW-1:0] rdata);
    bit got = 0;
    if (port_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    else        begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if ((port_b ? b_ack : a_ack) === 1'b1) got = 1;
    end
    rdata = port_b ? b_rdata : a_rdata;
    if (port_b) b_req = 0; else a_req = 0;
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL xfer_ack: got no ack, expected ack within 20 cycles"); end
    tick();
  endtask

  task automatic test_reset();
    reset = 0; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    tick(); tick();
    tests_run++; if (owner !== 2'b00) begin tests_failed++; $display("FAIL rst_owner: got %0h, expected 0", owner); end
    tests_run++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin tests_failed++; $display("FAIL rst_ack: got %b%b, expected 00", a_ack, b_ack); end
    tests_run++; if (m_we !== 1'b0 || m_re !== 1'b0) begin tests_failed++; $display("FAIL rst_strobe: got %b%b, expected 00", m_we, m_re); end
    tests_run++; if (m_addr !== 8'h00 || m_wdata !== 8'h00) begin tests_failed++; $display("FAIL rst_bus: got %0h/%0h, expected 0/0", m_addr, m_wdata); end
    tests_run++; if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin tests_failed++; $display("FAIL rst_rdata: got %0h/%0h, expected 0/0", a_rdata, b_rdata); end
    reset = 1;
  endtask

  task automatic test_write();
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h5A;
    tick();
    tests_run++; if (m_we !== 1'b1 || m_re !== 1'b0) begin tests_failed++; $display("FAIL wr_strobe: got we=%b re=%b, expected we=1 re=0", m_we, m_re); end
    tests_run++; if (m_addr !== 8'h10 || m_wdata !== 8'h5A) begin tests_failed++; $display("FAIL wr_bus: got %0h/%0h, expected 10/5a", m_addr, m_wdata); end
    tests_run++; if (owner !== 2'b01 || a_ack !== 1'b0) begin tests_failed++; $display("FAIL wr_owner: got owner=%0h ack=%b, expected 1/0", owner, a_ack); end
    tick();
    tests_run++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin tests_failed++; $display("FAIL wr_ack: got a=%b b=%b, expected a=1 b=0", a_ack, b_ack); end
    tests_run++; if (m_we !== 1'b0) begin tests_failed++; $display("FAIL wr_we_done: got %b, expected 0", m_we); end
    a_req = 0;
    tick();
    tests_run++; if (a_ack !== 1'b0 || owner !== 2'b00) begin tests_failed++; $display("FAIL wr_idle: got ack=%b owner=%0h, expected 0/0", a_ack, owner); end
    tests_run++; if (m_addr !== 8'h10 || m_wdata !== 8'h5A) begin tests_failed++; $display("FAIL wr_hold: got %0h/%0h, expected 10/5a", m_addr, m_wdata); end
  endtask

  task automatic test_read();
    b_req = 1; b_we = 0; b_addr = 8'h10;
    tick();
    tests_run++; if (m_re !== 1'b1 || m_we !== 1'b0 || m_addr !== 8'h10) begin tests_failed++; $display("FAIL rd_strobe: got re=%b we=%b addr=%0h, expected 1/0/10", m_re, m_we, m_addr); end
    tests_run++; if (owner !== 2'b10) begin tests_failed++; $display("FAIL rd_owner: got %0h, expected 2", owner); end
    for (int c = 2; c < 2 + RD_LAT; c++) begin
      tick();
      tests_run++; if (b_ack !== 1'b0 || m_re !== 1'b0) begin tests_failed++; $display("FAIL rd_wait: got ack=%b re=%b, expected 0/0", b_ack, m_re); end
    end
    tick();
    tests_run++; if (b_ack !== 1'b1 || a_ack !== 1'b0) begin tests_failed++; $display("FAIL rd_ack: got b=%b a=%b, expected b=1 a=0", b_ack, a_ack); end
    tests_run++; if (b_rdata !== 8'h5A) begin tests_failed++; $display("FAIL rd_data: got %0h, expected 5a", b_rdata); end
    tests_run++; if (a_rdata !== 8'h00) begin tests_failed++; $display("FAIL rd_other_rdata: got %0h, expected 0", a_rdata); end
    b_req = 0;
    tick();
  endtask

  task automatic test_addr_latch();
    logic [DW-1:0] rd;
    do_xfer(0, 1, 8'h20, 8'h77, rd);
    do_xfer(1, 1, 8'h30, 8'h33, rd);
    a_req = 1; a_we = 0; a_addr = 8'h20;
    tick();
    a_req = 0; a_addr = 8'h30;
    #1;
    tests_run++; if (m_re !== 1'b1 || m_addr !== 8'h20) begin tests_failed++; $display("FAIL latch_addr: got re=%b addr=%0h, expected 1/20", m_re, m_addr); end
    for (int c = 0; c < RD_LAT; c++) tick();
    tick();
    tests_run++; if (a_ack !== 1'b1 || a_rdata !== 8'h77) begin tests_failed++; $display("FAIL latch_ack: got ack=%b data=%0h, expected 1/77", a_ack, a_rdata); end
    tick();
    tick();
    tests_run++; if (owner !== 2'b00 || a_ack !== 1'b0) begin tests_failed++; $display("FAIL latch_no_retry: got owner=%0h ack=%b, expected 0/0", owner, a_ack); end
  endtask

  task automatic test_tie();
    reset = 0; a_req = 0; b_req = 0;
    tick();
    reset = 1;
    a_req = 1; a_we = 1; a_addr = 8'h40; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 8'h41; b_wdata = 8'h22;
    tick();
    tests_run++; if (owner !== 2'b01 || m_addr !== 8'h40) begin tests_failed++; $display("FAIL tie_first: got owner=%0h addr=%0h, expected 1/40", owner, m_addr); end
    tick();
    tests_run++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin tests_failed++; $display("FAIL tie_a_ack: got a=%b b=%b, expected 1/0", a_ack, b_ack); end
    tick();
    tests_run++; if (owner !== 2'b00) begin tests_failed++; $display("FAIL tie_idle1: got %0h, expected 0", owner); end
    tick();
    tests_run++; if (owner !== 2'b10 || m_addr !== 8'h41 || m_wdata !== 8'h22) begin tests_failed++; $display("FAIL tie_second: got owner=%0h addr=%0h data=%0h, expected 2/41/22", owner, m_addr, m_wdata); end
    tick();
    tests_run++; if (b_ack !== 1'b1 || a_ack !== 1'b0) begin tests_failed++; $display("FAIL tie_b_ack: got b=%b a=%b, expected 1/0", b_ack, a_ack); end
    tick();
    tick();
    tests_run++; if (owner !== 2'b01) begin tests_failed++; $display("FAIL tie_third: got %0h, expected 1", owner); end
    tick();
    tests_run++; if (a_ack !== 1'b1) begin tests_failed++; $display("FAIL tie_third_ack: got %b, expected 1", a_ack); end
    a_req = 0; b_req = 0;
    tick();
    tick();
    tests_run++; if (owner !== 2'b00) begin tests_failed++; $display("FAIL tie_quiet: got %0h, expected 0", owner); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    do_xfer(1, 0, 8'h10, 8'h00, rd);
    tests_run++; if (rd !== 8'h5A) begin tests_failed++; $display("FAIL mid_pre_read: got %0h, expected 5a", rd); end
    b_req = 1; b_we = 0; b_addr = 8'h20;
    tick();
    tests_run++; if (m_re !== 1'b1) begin tests_failed++; $display("FAIL mid_access: got %b, expected 1", m_re); end
    tick();
    reset = 0; b_req = 0;
    tick();
    tests_run++; if (owner !== 2'b00 || b_ack !== 1'b0) begin tests_failed++; $display("FAIL mid_abort: got owner=%0h ack=%b, expected 0/0", owner, b_ack); end
    tests_run++; if (b_rdata !== 8'h00) begin tests_failed++; $display("FAIL mid_rdata: got %0h, expected 0", b_rdata); end
    reset = 1;
    for (int c = 0; c < 6; c++) begin
      tests_run++;
      if (b_ack !== 1'b0 || m_re !== 1'b0 || m_we !== 1'b0 || owner !== 2'b00) begin
        tests_failed++; $display("FAIL mid_quiet: got ack=%b re=%b we=%b owner=%0h, expected all 0", b_ack, m_re, m_we, owner);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [TW-1:0] t;
    logic [AW-1:0] ta;
    logic [DW-1:0] dummy;
    logic [DW-1:0] a_rd_exp = '0;
    logic [DW-1:0] b_rd_exp = '0;
    bit a_pend = 0, b_pend = 0;
    int a_age = 0, b_age = 0, age_max = 0, a_passed = 0, b_passed = 0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = DW'($urandom);
      do_xfer(i[0], 1, AW'(i), ref_mem[i], dummy);
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      tests_run++; if (m_we && m_re) begin tests_failed++; $display("FAIL rnd_strobes: got we=1 re=1, expected at most one"); end
      tests_run++; if (a_ack && b_ack) begin tests_failed++; $display("FAIL rnd_dual_ack: got both acks, expected at most one"); end
      if (a_ack) begin
        tests_run++;
        if (!a_pend) begin tests_failed++; $display("FAIL rnd_a_spurious: got ack, expected none at cycle %0d", cyc); end
        else begin
          t = a_exp_q.pop_front(); ta = t[DW +: AW];
          if (t[TW-1]) ref_mem[ta[3:0]] = t[DW-1:0]; else a_rd_exp = ref_mem[ta[3:0]];
          a_pend = 0; a_req = 0;
          if (b_pend) b_passed++;
        end
      end
      if (b_ack) begin
        tests_run++;
        if (!b_pend) begin tests_failed++; $display("FAIL rnd_b_spurious: got ack, expected none at cycle %0d", cyc); end
        else begin
          t = b_exp_q.pop_front(); ta = t[DW +: AW];
          if (t[TW-1]) ref_mem[ta[3:0]] = t[DW-1:0]; else b_rd_exp = ref_mem[ta[3:0]];
          b_pend = 0; b_req = 0;
          if (a_pend) a_passed++;
        end
      end
      tests_run++; if (a_rdata !== a_rd_exp) begin tests_failed++; $display("FAIL rnd_a_rdata: got %0h, expected %0h at cycle %0d", a_rdata, a_rd_exp, cyc); end
      tests_run++; if (b_rdata !== b_rd_exp) begin tests_failed++; $display("FAIL rnd_b_rdata: got %0h, expected %0h at cycle %0d", b_rdata, b_rd_exp, cyc); end
      tests_run++; if (a_passed > 1 || b_passed > 1) begin tests_failed++; $display("FAIL rnd_fair: got %0d/%0d bypasses, expected <=1", a_passed, b_passed); end
      if (a_pend) begin a_age++; if (a_age > age_max) age_max = a_age; end
      if (b_pend) begin b_age++; if (b_age > age_max) age_max = b_age; end
      if (!a_pend && cyc < 9900 && $urandom_range(0, 2) == 0) begin
        a_we = 1'($urandom_range(0, 1)); a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
        a_req = 1; a_exp_q.push_back({a_we, a_addr, a_wdata});
        a_pend = 1; a_age = 0; a_passed = 0;
      end
      if (!b_pend && cyc < 9900 && $urandom_range(0, 2) == 0) begin
        b_we = 1'($urandom_range(0, 1)); b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
        b_req = 1; b_exp_q.push_back({b_we, b_addr, b_wdata});
        b_pend = 1; b_age = 0; b_passed = 0;
      end
    end
    tests_run++; if (a_pend || b_pend) begin tests_failed++; $display("FAIL rnd_drain: got pending a=%b b=%b, expected none", a_pend, b_pend); end
    tests_run++; if (age_max > AGE_LIMIT) begin tests_failed++; $display("FAIL rnd_latency: got %0d cycles, expected <= %0d", age_max, AGE_LIMIT); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_latch();
    test_tie();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
